// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Purpose  : RISC-V immediate generator (I/S/B/J/U/CSR-zimm) with a single
//             valid/ready output register between decode and execute.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:7]     Instr,
    input  logic [2:0]      ImmSrc,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            ImmIllegal,
    output logic            out_valid,
    input  logic            out_ready
);

    // Only RV32 and RV64 result widths are meaningful.
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_illegal
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] c_FMT_I = 3'b000;
    localparam logic [2:0] c_FMT_S = 3'b001;
    localparam logic [2:0] c_FMT_B = 3'b010;
    localparam logic [2:0] c_FMT_J = 3'b011;
    localparam logic [2:0] c_FMT_U = 3'b100;
    localparam logic [2:0] c_FMT_Z = 3'b101;

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_in_xfer;

    // Sign of every signed format is instruction bit 31.
    assign w_sext    = {XLEN{Instr[31]}};
    assign w_in_xfer = in_valid && in_ready;

    // Immediate decode: start from the all-sign pattern and overwrite the
    // low bits, so the same code works for both XLEN values (RV64 U-format
    // is sign-extended above bit 31 for free).
    always_comb begin
        w_imm     = w_sext;
        w_illegal = 1'b0;
        case (ImmSrc)
            c_FMT_I: w_imm[11:0] = Instr[31:20];
            c_FMT_S: w_imm[11:0] = {Instr[31:25], Instr[11:7]};
            c_FMT_B: w_imm[11:0] = {Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            c_FMT_J: w_imm[19:0] = {Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            c_FMT_U: w_imm[31:0] = {Instr[31:12], 12'b0};
            c_FMT_Z: begin
                // CSR zimm is an unsigned 5-bit field.
                w_imm      = '0;
                w_imm[4:0] = Instr[19:15];
            end
            default: begin
                w_imm     = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // State register: EMPTY/FULL occupancy of the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: fill on accept, drain when consumed with nothing new arriving.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (out_ready && !w_in_xfer) begin
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // Output handshake signals; in_ready is the only combinational in->out path.
    always_comb begin
        out_valid = (r_state == c_ST_FULL);
        in_ready  = (r_state == c_ST_EMPTY) || out_ready;
    end

    // Result register: loads only on an input transfer, otherwise holds the
    // last value (including after the stage drains).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imm     <= '0;
            r_illegal <= 1'b0;
        end else if (w_in_xfer) begin
            r_imm     <= w_imm;
            r_illegal <= w_illegal;
        end
    end

    assign ImmExt     = r_imm;
    assign ImmIllegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Purpose  : Directed plus streamed checks of imm_gen_pipe at XLEN 32 and 64.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:7] instr_a;
    logic [2:0]  src_a;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, illegal_a;
    logic [31:0] imm_a;

    logic [31:7] instr_b;
    logic [2:0]  src_b;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, illegal_b;
    logic [63:0] imm_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset), .Instr(instr_a), .ImmSrc(src_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .ImmExt(imm_a),
        .ImmIllegal(illegal_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset), .Instr(instr_b), .ImmSrc(src_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .ImmExt(imm_b),
        .ImmIllegal(illegal_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request to the 32-bit (wide=0) or 64-bit (wide=1) instance.
    task automatic send(input bit wide, input logic [31:0] word, input logic [2:0] src);
        if (wide) begin
            instr_b = word[31:7]; src_b = src; in_valid_b = 1'b1;
        end else begin
            instr_a = word[31:7]; src_a = src; in_valid_a = 1'b1;
        end
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    // Reference immediate built from signed field values.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] f, input int xlen);
        logic signed [11:0] a12;
        logic signed [12:0] a13;
        logic signed [20:0] a21;
        logic signed [31:0] a32;
        logic [63:0]        r;
        r = 64'd0;
        case (f)
            3'd0: begin a12 = w[31:20];                                   r = a12; end
            3'd1: begin a12 = {w[31:25], w[11:7]};                        r = a12; end
            3'd2: begin a13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};     r = a13; end
            3'd3: begin a21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};   r = a21; end
            3'd4: begin a32 = {w[31:12], 12'h000};                        r = a32; end
            3'd5: r = {59'd0, w[19:15]};
            default: r = 64'd0;
        endcase
        if (xlen == 32) r[63:32] = 32'd0;
        return r;
    endfunction

    logic [63:0] sb_imm[$];
    logic        sb_ill[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          accepted;
        int          drained;
        int          cyc;

        reset = 1'b1;
        instr_a = '0; src_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        instr_b = '0; src_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_imm",       64'(imm_a),       64'd0);
        check("rst_illegal",   64'(illegal_a),   64'd0);
        check("rst_in_ready",  64'(in_ready_a),  64'd1);
        check("rst_imm64",     imm_b,            64'd0);

        // Directed formats, XLEN=32
        send(0, 32'hFFF00093, 3'b000);
        check("i_valid",   64'(out_valid_a), 64'd1);
        check("i_imm",     64'(imm_a),       64'hFFFF_FFFF);
        check("i_illegal", 64'(illegal_a),   64'd0);
        send(0, 32'hFE000EE3, 3'b010);
        check("b_imm", 64'(imm_a), 64'hFFFF_FFFC);
        send(0, 32'h123450B7, 3'b100);
        check("u_imm", 64'(imm_a), 64'h1234_5000);
        send(0, 32'hFFFFD073, 3'b101);
        check("z_imm", 64'(imm_a), 64'h0000_001F);
        send(0, 32'hFE112C23, 3'b001);
        check("s_imm", 64'(imm_a), 64'hFFFF_FFF8);
        send(0, 32'h001000EF, 3'b011);
        check("j_pos_imm", 64'(imm_a), 64'h0000_0800);
        send(0, 32'hFFFFF0EF, 3'b011);
        check("j_neg_imm", 64'(imm_a), 64'hFFFF_FFFE);

        // Directed formats, XLEN=64
        send(1, 32'h800000B7, 3'b100);
        check("u64_valid", 64'(out_valid_b), 64'd1);
        check("u64_imm",   imm_b, 64'hFFFF_FFFF_8000_0000);
        send(1, 32'hFE112C23, 3'b001);
        check("s64_imm",   imm_b, 64'hFFFF_FFFF_FFFF_FFF8);
        send(1, 32'hFFFFD073, 3'b101);
        check("z64_imm",   imm_b, 64'h0000_0000_0000_001F);
        send(1, 32'hFFF00093, 3'b000);
        check("i64_imm",   imm_b, 64'hFFFF_FFFF_FFFF_FFFF);

        // Illegal encodings, then recovery
        send(0, 32'hFFFFFFFF, 3'b110);
        check("ill110_imm",  64'(imm_a),     64'd0);
        check("ill110_flag", 64'(illegal_a), 64'd1);
        send(0, 32'hFFFFFFFF, 3'b111);
        check("ill111_flag", 64'(illegal_a), 64'd1);
        send(0, 32'h123450B7, 3'b100);
        check("legal_after_ill_flag", 64'(illegal_a), 64'd0);
        check("legal_after_ill_imm",  64'(imm_a),     64'h1234_5000);

        // Let the stage drain: last value must be kept
        tick();
        check("drain_valid", 64'(out_valid_a), 64'd0);
        check("drain_hold",  64'(imm_a),       64'h1234_5000);

        // Backpressure
        out_ready_a = 1'b0;
        send(0, 32'hFFF00093, 3'b000);
        instr_a = 25'h0246_8AC >> 0; // arbitrary second request
        w = 32'h001000EF;
        instr_a = w[31:7]; src_a = 3'b011; in_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready",  64'(in_ready_a),  64'd0);
            check("bp_out_valid", 64'(out_valid_a), 64'd1);
            check("bp_imm",       64'(imm_a),       64'hFFFF_FFFF);
            tick();
        end
        out_ready_a = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        check("bp_next_valid", 64'(out_valid_a), 64'd1);
        check("bp_next_imm",   64'(imm_a),       64'h0000_0800);
        tick();
        check("bp_empty", 64'(out_valid_a), 64'd0);

        // Reset while FULL and stalled, with a competing input transfer
        out_ready_a = 1'b0;
        send(0, 32'hFE000EE3, 3'b010);
        check("pre_rst_valid", 64'(out_valid_a), 64'd1);
        w = 32'h123450B7;
        instr_a = w[31:7]; src_a = 3'b100; in_valid_a = 1'b1; reset = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid_a), 64'd0);
        check("mid_rst_imm",   64'(imm_a),       64'd0);
        reset = 1'b0; in_valid_a = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready_a),  64'd1);
        check("post_rst_valid",    64'(out_valid_a), 64'd0);

        // Streamed random requests with random backpressure
        accepted = 0;
        drained  = 0;
        cyc      = 0;
        while ((accepted < 100 || sb_imm.size() != 0) && cyc < 3000) begin
            cyc++;
            if (accepted < 100) begin
                w = $urandom;
                instr_a    = w[31:7];
                src_a      = 3'($urandom_range(0, 7));
                in_valid_a = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid_a = 1'b0;
            end
            out_ready_a = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid_a && out_ready_a) begin
                if (sb_imm.size() == 0) begin
                    check("stream_spurious_output", 64'd1, 64'd0);
                end else begin
                    check("stream_imm",     64'(imm_a),     sb_imm.pop_front());
                    check("stream_illegal", 64'(illegal_a), 64'(sb_ill.pop_front()));
                    drained++;
                end
            end
            if (in_valid_a && in_ready_a) begin
                sb_imm.push_back(ref_imm({instr_a, 7'd0}, src_a, 32));
                sb_ill.push_back(src_a[2] & src_a[1]);
                accepted++;
            end
            tick();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        check("stream_count", 64'(drained), 64'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
